// File: rtl/acc_readout_pkg.sv
// Shared configuration for the accumulator readout block: default sizes,
// FSM state and walk-phase encodings, and triangle address helpers.
// Optional feature macro: ACC_READOUT_MIRROR_EN (full mirrored Hessian output).
package acc_readout_pkg;

  localparam int ACC_MAT_DIM = 6;
  localparam int ACC_DATA_BW = 64;

`ifdef ACC_READOUT_MIRROR_EN
  localparam bit ACC_MIRROR_ON = 1'b1;
`else
  localparam bit ACC_MIRROR_ON = 1'b0;
`endif

  typedef enum logic {IDLE, SEND} acc_readout_state_t;

  // Which part of the frame the row/col walk is currently in.
  typedef enum logic {PH_MAT, PH_GRAD} acc_phase_t;

  // Upper-triangle slot of element (row, col), row <= col, row-major packing.
  // row*(row-1) is always even, so the halving is a plain shift.
  function automatic int tri_slot(input int row, input int col, input int dim);
    return row * dim - ((row * (row - 1)) >> 1) + (col - row);
  endfunction

  // Number of words streamed per frame.
  function automatic int num_out(input int dim);
    return ACC_MIRROR_ON ? dim * dim + dim : dim * (dim + 1) / 2 + dim;
  endfunction

endpackage

// File: rtl/acc_readout_tri_addr.sv
// acc_tri_addr: combinational map from the (row, col, phase) walk position to
// a snapshot slot. With ACC_READOUT_MIRROR_EN defined, lower-triangle
// positions are folded onto their upper-triangle twin.
module acc_tri_addr
  import acc_readout_pkg::*;
#(
  parameter int MAT_DIM = ACC_MAT_DIM,
  parameter int RC_BW   = $clog2(MAT_DIM),
  parameter int SLOT_BW = $clog2(MAT_DIM * (MAT_DIM + 1) / 2 + MAT_DIM)
) (
  input  logic [RC_BW-1:0]   i_row,
  input  logic [RC_BW-1:0]   i_col,
  input  acc_phase_t         i_phase,
  output logic [SLOT_BW-1:0] o_slot
);

  localparam int NUM_TRI = MAT_DIM * (MAT_DIM + 1) / 2;

  logic [RC_BW-1:0] r;
  logic [RC_BW-1:0] c;

  // Resolve the walk position to the slot holding its value.
  always_comb begin
    r = i_row;
    c = i_col;
`ifdef ACC_READOUT_MIRROR_EN
    if (i_row > i_col) begin
      r = i_col;
      c = i_row;
    end
`endif
    if (i_phase == PH_GRAD) begin
      o_slot = SLOT_BW'(NUM_TRI + int'(i_col));
    end else begin
      o_slot = SLOT_BW'(tri_slot(int'(r), int'(c), MAT_DIM));
    end
  end

endmodule

// File: rtl/acc_readout.sv
// acc_readout: snapshots the MulAcc bank on i_acc_done, clears the bank, and
// streams the Hessian triangle (or full mirrored matrix) plus gradient over a
// valid/ready interface, one signed word per handshake.
// Optional feature macro: ACC_READOUT_MIRROR_EN.
module acc_readout
  import acc_readout_pkg::*;
#(
  parameter  int MAT_DIM = ACC_MAT_DIM,
  parameter  int DATA_BW = ACC_DATA_BW,
  localparam int NUM_TRI = MAT_DIM * (MAT_DIM + 1) / 2,
  localparam int NUM_ACC = NUM_TRI + MAT_DIM,
  localparam int NUM_OUT = num_out(MAT_DIM),
  localparam int IDX_BW  = $clog2(NUM_OUT)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_acc_done,
  input  logic [NUM_ACC*DATA_BW-1:0] i_acc_data,
  input  logic                       i_abort,
  input  logic                       i_ready,
  output logic                       o_acc_clear,
  output logic                       o_valid,
  output logic [DATA_BW-1:0]         o_data,
  output logic [IDX_BW-1:0]          o_index,
  output logic                       o_last,
  output logic                       o_busy,
  output logic                       o_overrun
);

  localparam int RC_BW   = $clog2(MAT_DIM);
  localparam int SLOT_BW = $clog2(NUM_ACC);
  localparam logic [RC_BW-1:0] RC_LAST = RC_BW'(MAT_DIM - 1);

  acc_readout_state_t state_q, state_d;
  acc_phase_t         phase_q, phase_d, nxt_phase;
  logic [RC_BW-1:0]   row_q, row_d, col_q, col_d, nxt_row, nxt_col;
  logic [IDX_BW-1:0]  idx_q, idx_d;
  logic [DATA_BW-1:0] data_q, data_d;
  logic               valid_q, valid_d, last_q, last_d;
  logic               clear_q, clear_d, overrun_q, overrun_d;
  logic               load, fin;
  logic [SLOT_BW-1:0] nxt_slot;
  logic [DATA_BW-1:0] snap_q [NUM_ACC];
  logic [DATA_BW-1:0] snap_d [NUM_ACC];

  // Next walk position: triangle (or full matrix) rows, then the gradient.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    nxt_row   = row_q;
    nxt_col   = col_q;
    nxt_phase = phase_q;
    if (phase_q == PH_GRAD) begin
      if (col_q != RC_LAST) nxt_col = col_q + 1'b1;
    end else if (col_q == RC_LAST) begin
      if (row_q == RC_LAST) begin
        nxt_phase = PH_GRAD;
        nxt_row   = '0;
        nxt_col   = '0;
      end else begin
        nxt_row = row_q + 1'b1;
`ifdef ACC_READOUT_MIRROR_EN
        nxt_col = '0;
`else
        nxt_col = row_q + 1'b1;
`endif
      end
    end else begin
      nxt_col = col_q + 1'b1;
    end
  end

  acc_tri_addr #(
    .MAT_DIM (MAT_DIM),
    .RC_BW   (RC_BW),
    .SLOT_BW (SLOT_BW)
  ) u_tri_addr (
    .i_row   (nxt_row),
    .i_col   (nxt_col),
    .i_phase (nxt_phase),
    .o_slot  (nxt_slot)
  );

  assign fin = (state_q == SEND) & i_ready & last_q;

  // FSM next state, counters and registered stream outputs.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    row_d     = row_q;
    col_d     = col_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    data_d    = data_q;
    last_d    = last_q;
    clear_d   = 1'b0;
    overrun_d = 1'b0;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_acc_done) begin
          // Word 0 is always slot 0; take it straight from the bank since
          // the snapshot is written on this same edge.
          state_d = SEND;
          load    = 1'b1;
          clear_d = 1'b1;
          phase_d = PH_MAT;
          row_d   = '0;
          col_d   = '0;
          idx_d   = '0;
          valid_d = 1'b1;
          data_d  = i_acc_data[0 +: DATA_BW];
          last_d  = (NUM_OUT == 1);
        end
      end
      SEND: begin
        overrun_d = i_acc_done;
        if (i_ready && !last_q) begin
          phase_d = nxt_phase;
          row_d   = nxt_row;
          col_d   = nxt_col;
          idx_d   = idx_q + 1'b1;
          data_d  = snap_q[nxt_slot];
          last_d  = (idx_q == IDX_BW'(NUM_OUT - 2));
        end
      end
    endcase
    if (fin || i_abort) begin
      state_d = IDLE;
      phase_d = PH_MAT;
      row_d   = '0;
      col_d   = '0;
      idx_d   = '0;
      valid_d = 1'b0;
      data_d  = '0;
      last_d  = 1'b0;
    end
    if (i_abort) begin
      load      = 1'b0;
      clear_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // Snapshot bank captures every accumulator in the frame-end cycle.
  always_comb begin
    snap_d = snap_q;
    if (load) begin
      for (int k = 0; k < NUM_ACC; k++) snap_d[k] = i_acc_data[k*DATA_BW +: DATA_BW];
    end
  end

  // Control and output registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      phase_q   <= PH_MAT;
      row_q     <= '0;
      col_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
      clear_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      row_q     <= row_d;
      col_q     <= col_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      last_q    <= last_d;
      clear_q   <= clear_d;
      overrun_q <= overrun_d;
    end
  end

  // Snapshot storage.
  // NOTE: this small register array is reset on purpose so a stream that
  // follows an abort never exposes uninitialised words; large RAM-style
  // arrays would normally be left unreset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_ACC; k++) snap_q[k] <= '0;
    end else begin
      snap_q <= snap_d;
    end
  end

  assign o_acc_clear = clear_q;
  assign o_valid     = valid_q;
  assign o_data      = data_q;
  assign o_index     = idx_q;
  assign o_last      = last_q;
  assign o_busy      = (state_q != IDLE);
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_acc_readout.sv
// Self-checking bench for acc_readout. A reference model enumerates the
// Hessian/gradient output order from the matrix definition and compares every
// streamed word against it under fixed, stalled and random ready patterns.
module tb_acc_readout;

  localparam int MAT_DIM = 6;
  localparam int DATA_BW = 64;
  localparam int NUM_TRI = MAT_DIM * (MAT_DIM + 1) / 2;
  localparam int NUM_ACC = NUM_TRI + MAT_DIM;
`ifdef ACC_READOUT_MIRROR_EN
  localparam bit MIRROR  = 1'b1;
  localparam int NUM_OUT = MAT_DIM * MAT_DIM + MAT_DIM;
`else
  localparam bit MIRROR  = 1'b0;
  localparam int NUM_OUT = NUM_ACC;
`endif
  localparam int IDX_BW = $clog2(NUM_OUT);

  logic                       i_clk;
  logic                       i_rst_n;
  logic                       i_acc_done;
  logic [NUM_ACC*DATA_BW-1:0] i_acc_data;
  logic                       i_abort;
  logic                       i_ready;
  logic                       o_acc_clear;
  logic                       o_valid;
  logic [DATA_BW-1:0]         o_data;
  logic [IDX_BW-1:0]          o_index;
  logic                       o_last;
  logic                       o_busy;
  logic                       o_overrun;

  acc_readout dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_acc_done  (i_acc_done),
    .i_acc_data  (i_acc_data),
    .i_abort     (i_abort),
    .i_ready     (i_ready),
    .o_acc_clear (o_acc_clear),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_index     (o_index),
    .o_last      (o_last),
    .o_busy      (o_busy),
    .o_overrun   (o_overrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int vectors;
  int miscompares;

  logic [DATA_BW-1:0] slot_v [NUM_ACC];
  logic [DATA_BW-1:0] exp_q [$];
  int                 tri_map [MAT_DIM][MAT_DIM];

  // Reference model: number the upper triangle row-major, then list every
  // streamed element of the matrix followed by the gradient.
  task automatic build_expected();
    int k;
    k = 0;
    for (int r = 0; r < MAT_DIM; r++)
      for (int c = r; c < MAT_DIM; c++) begin
        tri_map[r][c] = k;
        k++;
      end
    exp_q.delete();
    for (int r = 0; r < MAT_DIM; r++)
      for (int c = 0; c < MAT_DIM; c++) begin
        if (c >= r) exp_q.push_back(slot_v[tri_map[r][c]]);
        else if (MIRROR) exp_q.push_back(slot_v[tri_map[c][r]]);
      end
    for (int g = 0; g < MAT_DIM; g++) exp_q.push_back(slot_v[NUM_TRI + g]);
  endtask

  task automatic drive_slots();
    for (int k = 0; k < NUM_ACC; k++) i_acc_data[k*DATA_BW +: DATA_BW] = slot_v[k];
    build_expected();
  endtask

  task automatic random_slots();
    for (int k = 0; k < NUM_ACC; k++) slot_v[k] = {$urandom, $urandom};
    drive_slots();
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Pulse i_acc_done and check the T+1 response.
  task automatic start_frame(input string tag);
    i_acc_done = 1'b1;
    step();
    i_acc_done = 1'b0;
    vectors++;
    if ({o_acc_clear, o_valid, o_busy, o_overrun} !== 4'b1110) begin
      $display("FAIL %s start: clear/valid/busy/overrun=%b want 1110", tag,
               {o_acc_clear, o_valid, o_busy, o_overrun});
      miscompares++;
    end
  endtask

  // Consume a whole frame, checking every presented word against the model.
  task automatic drain(input string tag, input bit rand_ready, input int stall_at,
                       input int stall_len, input int inject_at, input int exp_ovr);
    int w, guard, stall, ovr, clr;
    bit hs, injected;
    w = 0; guard = 0; stall = 0; ovr = 0; clr = 0; injected = 1'b0;
    while (w < NUM_OUT && guard < 1000) begin
      vectors++;
      if ({o_valid, o_index, o_last, o_data} !==
          {1'b1, IDX_BW'(w), (w == NUM_OUT - 1), exp_q[w]}) begin
        $display("FAIL %s word %0d: v=%b idx=%0d last=%b data=%h want idx=%0d data=%h",
                 tag, w, o_valid, o_index, o_last, o_data, w, exp_q[w]);
        miscompares++;
      end
      if (o_overrun) ovr++;
      if (o_acc_clear) clr++;
      if (w == stall_at && stall < stall_len) begin
        i_ready = 1'b0;
        stall++;
      end else begin
        i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (w == inject_at && !injected && i_ready) begin
        i_acc_done = 1'b1;
        i_acc_data = ~i_acc_data;
        injected   = 1'b1;
      end else begin
        i_acc_done = 1'b0;
      end
      hs = i_ready;
      step();
      guard++;
      if (hs) w++;
    end
    i_acc_done = 1'b0;
    i_ready    = 1'b1;
    if (guard >= 1000) begin
      $display("FAIL %s timeout: reached word %0d of %0d", tag, w, NUM_OUT);
      miscompares++;
    end
    if (o_overrun) ovr++;
    if (o_acc_clear) clr++;
    vectors++;
    if ({o_valid, o_busy} !== 2'b00) begin
      $display("FAIL %s end: valid/busy=%b want 00", tag, {o_valid, o_busy});
      miscompares++;
    end
    vectors++;
    if (ovr != exp_ovr || clr != 1) begin
      $display("FAIL %s pulses: overrun=%0d clear=%0d want overrun=%0d clear=1",
               tag, ovr, clr, exp_ovr);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_acc_done = 1'b0; i_abort = 1'b0; i_ready = 1'b1; i_acc_data = '0;
    #1;
    vectors++;
    if ({o_acc_clear, o_valid, o_data, o_index, o_last, o_busy, o_overrun} !== '0) begin
      $display("FAIL reset: outputs v=%b data=%h idx=%0d busy=%b want all 0",
               o_valid, o_data, o_index, o_busy);
      miscompares++;
    end
    repeat (2) @(posedge i_clk);
    @(negedge i_clk) i_rst_n = 1'b1;
    step();
  endtask

  task automatic test_stream();
    for (int k = 0; k < NUM_ACC; k++) slot_v[k] = DATA_BW'(k + 1);
    drive_slots();
    start_frame("stream");
    drain("stream", 1'b0, -1, 0, -1, 0);
  endtask

  task automatic test_stall();
    for (int k = 0; k < NUM_ACC; k++) slot_v[k] = DATA_BW'(k + 1);
    drive_slots();
    start_frame("stall");
    drain("stall", 1'b0, 3, 4, -1, 0);
  endtask

  task automatic test_negative();
    random_slots();
    slot_v[1] = 64'hFFFF_FFFF_FFFF_FFFB;
    drive_slots();
    start_frame("neg");
    drain("neg", 1'b0, -1, 0, -1, 0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      random_slots();
      start_frame("random");
      drain("random", 1'b1, -1, 0, -1, 0);
    end
  endtask

  task automatic test_overrun();
    random_slots();
    start_frame("overrun");
    drain("overrun", 1'b0, -1, 0, 10, 1);
  endtask

  task automatic test_back_to_back();
    random_slots();
    start_frame("b2b_a");
    drain("b2b_a", 1'b0, -1, 0, NUM_OUT - 1, 1);
    random_slots();
    start_frame("b2b_b");
    drain("b2b_b", 1'b1, -1, 0, -1, 0);
  endtask

  task automatic test_reset_mid();
    int g;
    random_slots();
    start_frame("rstmid");
    i_ready = 1'b1;
    g = 0;
    while (o_index != IDX_BW'(12) && g < 40) begin
      step();
      g++;
    end
    vectors++;
    if (g >= 40) begin
      $display("FAIL rstmid reach: idx=%0d want 12", o_index);
      miscompares++;
    end
    #2 i_rst_n = 1'b0;
    #1;
    vectors++;
    if ({o_acc_clear, o_valid, o_data, o_index, o_last, o_busy, o_overrun} !== '0) begin
      $display("FAIL rstmid async: v=%b data=%h idx=%0d busy=%b want all 0",
               o_valid, o_data, o_index, o_busy);
      miscompares++;
    end
    @(negedge i_clk) i_rst_n = 1'b1;
    step();
    random_slots();
    start_frame("rstmid_new");
    drain("rstmid_new", 1'b0, -1, 0, -1, 0);
  endtask

  task automatic test_abort();
    int g;
    random_slots();
    start_frame("abort");
    i_ready = 1'b1;
    g = 0;
    while (o_index != IDX_BW'(5) && g < 40) begin
      step();
      g++;
    end
    vectors++;
    if (g >= 40) begin
      $display("FAIL abort reach: idx=%0d want 5", o_index);
      miscompares++;
    end
    i_abort = 1'b1;
    i_acc_done = 1'b1;
    step();
    i_abort = 1'b0;
    i_acc_done = 1'b0;
    vectors++;
    if ({o_valid, o_overrun, o_acc_clear, o_busy, o_index, o_last} !== '0) begin
      $display("FAIL abort next: v=%b ovr=%b clr=%b busy=%b idx=%0d want all 0",
               o_valid, o_overrun, o_acc_clear, o_busy, o_index);
      miscompares++;
    end
    step();
    vectors++;
    if ({o_valid, o_overrun, o_acc_clear} !== 3'b000) begin
      $display("FAIL abort settle: v/ovr/clr=%b want 000", {o_valid, o_overrun, o_acc_clear});
      miscompares++;
    end
    random_slots();
    start_frame("abort_new");
    drain("abort_new", 1'b0, -1, 0, -1, 0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_stream();
    test_stall();
    test_negative();
    test_random();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
